leb128_decoder: RTL and testbench

Streaming decoder for WebAssembly LEB128 immediates (signed and unsigned, 32- and 64-bit), sitting between the ROM byte fetch and the CPU execute stage. It consumes one immediate byte per accepted handshake, accumulates the 7-bit groups, and produces a 64-bit operand for instructions such as `i32.const`, `i64.const` and memory offsets. Malformed encodings raise a trap code instead of a value.

---
 rtl/wasm_pkg.sv | 38 +++
 rtl/leb128_sign_extend.sv | 31 +++
 rtl/leb128_decoder.sv | 124 ++++++++++++
 tb/tb_leb128_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wasm_pkg.sv
// Shared definitions for the WebAssembly immediate decoder.
// Holds the decoder state encoding, trap codes, per-width maximum
// encoded lengths and the unused-bit check applied to a final byte
// that reaches the maximum length.
// The unused-bit check is only used when LEB128_STRICT_EN is defined.
package wasm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } leb_state_e;

  localparam logic [1:0] LEB_TRAP_NONE     = 2'd0;
  localparam logic [1:0] LEB_TRAP_OVERLONG = 2'd1;
  localparam logic [1:0] LEB_TRAP_UNUSED   = 2'd2;

  localparam logic [3:0] LEB_MAX_LEN_32 = 4'd5;
  localparam logic [3:0] LEB_MAX_LEN_64 = 4'd10;

  // Returns 1 when the payload bits of a maximum-length final byte
  // that lie beyond the target width are not a valid extension.
  function automatic logic leb_unused_bad(input logic [7:0] b,
                                          input logic       is_signed,
                                          input logic       is_wide);
    logic bad;
    if (!is_wide) begin
      if (!is_signed) bad = (b[6:4] != 3'b000);
      else            bad = (b[6:4] != {3{b[3]}});
    end else begin
      if (!is_signed) bad = (b[6:1] != 6'd0);
      else            bad = !((b[6:0] == 7'h00) || (b[6:0] == 7'h7F));
    end
    return bad;
  endfunction

endpackage

// File: rtl/leb128_sign_extend.sv
// Final value shaping for a completed LEB128 decode.
// Sign-extends the accumulated groups from the last payload bit when the
// encoding is signed and shorter than the target width, then clears the
// upper half for 32-bit targets (bits above 32 from a 5-byte encoding
// are dropped here as well).
module leb128_sign_extend
  import wasm_pkg::*;
(
  input  logic [63:0] acc_i,
  input  logic [6:0]  nbits_i,
  input  logic        signed_i,
  input  logic        wide_i,
  output logic [63:0] value_o
);

  logic [6:0]  target_w;
  logic        sign_bit;
  logic        extend;
  logic [63:0] ext_mask;

  // Decide whether and where to extend, then mask for the target width.
  always_comb begin
    target_w = wide_i ? 7'd64 : 7'd32;
    sign_bit = |(acc_i & (64'd1 << (nbits_i - 7'd1)));
    extend   = signed_i && sign_bit && (nbits_i < target_w);
    ext_mask = ~64'd0 << nbits_i;
    value_o  = extend ? (acc_i | ext_mask) : acc_i;
    if (!wide_i) value_o[63:32] = 32'd0;
  end

endmodule

// File: rtl/leb128_decoder.sv
// Streaming LEB128 immediate decoder (signed/unsigned, 32/64-bit target).
// Accepts one byte per in_valid/in_ready handshake, accumulates 7-bit
// groups and presents the operand until out_ready. Overlong encodings
// trap with code 1. Defining LEB128_STRICT_EN also rejects maximum-length
// final bytes whose unused bits are not a proper extension (trap code 2).
module leb128_decoder
  import wasm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_i,
  input  logic        wide,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_value,
  output logic [3:0]  out_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  trap
);

  leb_state_e  state_q;
  logic [63:0] acc_q;
  logic [3:0]  n_q;
  logic        signed_q;
  logic        wide_q;
  logic [63:0] out_value_q;
  logic [3:0]  out_len_q;
  logic [1:0]  trap_q;

  logic [6:0]  shamt;
  logic [6:0]  nbits;
  logic [63:0] acc_d;
  logic [3:0]  n_d;
  logic [3:0]  max_len;
  logic        at_max;
  logic        accept;
  logic        strict_bad;
  logic [63:0] final_value;

  // Next accumulator and byte count for the byte currently offered.
  always_comb begin
    shamt   = {3'd0, n_q} * 7'd7;
    nbits   = shamt + 7'd7;
    acc_d   = acc_q | ({57'd0, in_data[6:0]} << shamt);
    n_d     = n_q + 4'd1;
    max_len = wide_q ? LEB_MAX_LEN_64 : LEB_MAX_LEN_32;
    at_max  = (n_d == max_len);
    accept  = in_valid && in_ready;
  end

`ifdef LEB128_STRICT_EN
  assign strict_bad = at_max && leb_unused_bad(in_data, signed_q, wide_q);
`else
  assign strict_bad = 1'b0;
`endif

  leb128_sign_extend u_sign_extend (
    .acc_i    (acc_d),
    .nbits_i  (nbits),
    .signed_i (signed_q),
    .wide_i   (wide_q),
    .value_o  (final_value)
  );

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign out_value = out_value_q;
  assign out_len   = out_len_q;
  assign trap      = trap_q;

  // Decode FSM: start/accumulate/hold result/trap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= 64'd0;
      n_q         <= 4'd0;
      signed_q    <= 1'b0;
      wide_q      <= 1'b0;
      out_value_q <= 64'd0;
      out_len_q   <= 4'd0;
      trap_q      <= LEB_TRAP_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            state_q  <= ST_ACCUM;
            acc_q    <= 64'd0;
            n_q      <= 4'd0;
            signed_q <= signed_i;
            wide_q   <= wide;
            trap_q   <= LEB_TRAP_NONE;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            n_q   <= n_d;
            if (in_data[7]) begin
              if (at_max) begin
                state_q <= ST_ERROR;
                trap_q  <= LEB_TRAP_OVERLONG;
              end
            end else if (strict_bad) begin
              state_q <= ST_ERROR;
              trap_q  <= LEB_TRAP_UNUSED;
            end else begin
              state_q     <= ST_DONE;
              out_value_q <= final_value;
              out_len_q   <= n_d;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed bench for leb128_decoder. All tasks begin and end on a falling
// clock edge, so inputs change and outputs are sampled away from the
// rising edge. Build with LEB128_STRICT_EN to exercise the strict variant.
module tb_leb128_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        signed_i = 1'b0;
  logic        wide = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  trap;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  leb128_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_i  (signed_i),
    .wide      (wide),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_value (out_value),
    .out_len   (out_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .trap      (trap)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic sgn, input logic wd);
    start = 1'b1; signed_i = sgn; wide = wd;
    @(negedge clk);
    start = 1'b0; signed_i = 1'b0; wide = 1'b0;
  endtask

  // Offers one byte for one cycle; the decoder must be ready for it.
  task automatic send_byte(input string tag, input logic [7:0] b);
    check({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_data = b;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Checks the held result, then completes the output handshake.
  task automatic expect_result(input string tag, input logic [63:0] v, input logic [3:0] len);
    check({tag, " out_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, " out_value"}, out_value, v);
    check({tag, " out_len"}, {60'd0, out_len}, {60'd0, len});
    check({tag, " trap"}, {62'd0, trap}, 64'd0);
    check({tag, " in_ready in DONE"}, {63'd0, in_ready}, 64'd0);
    $display("txn %s: value=%h len=%0d", tag, out_value, out_len);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    // Reset state
    idle(2);
    check("rst in_ready", {63'd0, in_ready}, 64'd0);
    check("rst out_valid", {63'd0, out_valid}, 64'd0);
    check("rst out_value", out_value, 64'd0);
    check("rst out_len", {60'd0, out_len}, 64'd0);
    check("rst trap", {62'd0, trap}, 64'd0);
    reset = 1'b1;
    idle(1);
    check("idle in_ready", {63'd0, in_ready}, 64'd0);

    // i32 signed 0x2A -> 42
    do_start(1'b1, 1'b0);
    check("t1 out_valid pre", {63'd0, out_valid}, 64'd0);
    send_byte("t1", 8'h2A);
    expect_result("t1 i32s 2A", 64'd42, 4'd1);

    // i32 signed 0x7F -> -1 with upper half clear
    do_start(1'b1, 1'b0);
    send_byte("t2", 8'h7F);
    expect_result("t2 i32s 7F", 64'h00000000FFFFFFFF, 4'd1);

    // i32 signed C0 BB 78 -> -123456, out_ready held high in advance
    do_start(1'b1, 1'b0);
    send_byte("t3", 8'hC0);
    send_byte("t3", 8'hBB);
    check("t3 out_valid mid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    send_byte("t3", 8'h78);
    check("t3 out_valid", {63'd0, out_valid}, 64'd1);
    check("t3 out_value", out_value, 64'h00000000FFFE1DC0);
    check("t3 out_len", {60'd0, out_len}, 64'd3);
    check("t3 in_ready in DONE", {63'd0, in_ready}, 64'd0);
    $display("txn t3 i32s C0BB78: value=%h len=%0d", out_value, out_len);
    @(negedge clk);
    out_ready = 1'b0;
    check("t3 out_valid drop", {63'd0, out_valid}, 64'd0);
    check("t3 back to idle", {63'd0, in_ready}, 64'd0);

    // i64 unsigned E5 8E 26 with input stalls and output backpressure
    do_start(1'b0, 1'b1);
    send_byte("t4", 8'hE5);
    idle(2);
    check("t4 stall out_valid", {63'd0, out_valid}, 64'd0);
    send_byte("t4", 8'h8E);
    send_byte("t4", 8'h26);
    for (int i = 0; i < 3; i++) begin
      check("t4 hold out_valid", {63'd0, out_valid}, 64'd1);
      check("t4 hold out_value", out_value, 64'd624485);
      @(negedge clk);
    end
    expect_result("t4 i64u E58E26", 64'd624485, 4'd3);

    // i64 signed 0x7F -> all ones
    do_start(1'b1, 1'b1);
    send_byte("t5", 8'h7F);
    expect_result("t5 i64s 7F", 64'hFFFFFFFFFFFFFFFF, 4'd1);

    // i64 unsigned 10-byte maximum: 80 x9, 01 -> 1<<63
    do_start(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) send_byte("t6", 8'h80);
    send_byte("t6", 8'h01);
    expect_result("t6 i64u 10B", 64'h8000000000000000, 4'd10);

    // i32 overlong: 80 x5 -> trap 1
    do_start(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte("t7", 8'h80);
    check("t7 trap", {62'd0, trap}, 64'd1);
    check("t7 in_ready", {63'd0, in_ready}, 64'd0);
    check("t7 out_valid", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b1; in_data = 8'h01;
    idle(3);
    in_valid = 1'b0;
    check("t7 trap held", {62'd0, trap}, 64'd1);
    check("t7 out_valid never", {63'd0, out_valid}, 64'd0);
    $display("txn t7 i32 overlong: trap=%0d", trap);
    do_start(1'b0, 1'b0);
    check("t7 trap cleared", {62'd0, trap}, 64'd0);
    send_byte("t7b", 8'h01);
    expect_result("t7b after trap", 64'd1, 4'd1);

    // i32 unsigned FF FF FF FF 7F
    do_start(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_byte("t8", 8'hFF);
    send_byte("t8", 8'h7F);
`ifdef LEB128_STRICT_EN
    check("t8 strict trap", {62'd0, trap}, 64'd2);
    check("t8 strict out_valid", {63'd0, out_valid}, 64'd0);
    check("t8 strict in_ready", {63'd0, in_ready}, 64'd0);
    $display("txn t8 i32u strict: trap=%0d", trap);
    do_start(1'b0, 1'b0);
    check("t8 strict trap cleared", {62'd0, trap}, 64'd0);
    send_byte("t8b", 8'h00);
    expect_result("t8b after trap", 64'd0, 4'd1);
`else
    expect_result("t8 i32u 5B", 64'h00000000FFFFFFFF, 4'd5);
`endif

    // Reset mid-decode after two bytes
    do_start(1'b0, 1'b0);
    send_byte("t9", 8'hFF);
    send_byte("t9", 8'hFF);
    reset = 1'b0;
    #1;
    check("t9 rst in_ready", {63'd0, in_ready}, 64'd0);
    check("t9 rst out_valid", {63'd0, out_valid}, 64'd0);
    check("t9 rst out_value", out_value, 64'd0);
    check("t9 rst out_len", {60'd0, out_len}, 64'd0);
    check("t9 rst trap", {62'd0, trap}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1; in_data = 8'h7F;
    idle(2);
    in_valid = 1'b0;
    check("t9 idle after rst", {63'd0, in_ready}, 64'd0);
    check("t9 no output after rst", {63'd0, out_valid}, 64'd0);
    $display("txn t9 reset mid-decode: out_value=%h", out_value);
    do_start(1'b0, 1'b1);
    send_byte("t9b", 8'h05);
    expect_result("t9b fresh decode", 64'd5, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
